// File: rtl/mult8x8_seq_ctrl.sv
// Iterative 8x8 unsigned multiplier: one shared 4x4 nibble multiplier, four shifted partial products.
// Optional macro APPROX_MODE_EN adds an 'approx' input that skips the lo*lo partial product.
module mult8x8_seq_ctrl #(
   parameter int PP_REG = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  a,
   input  logic [7:0]  b,
`ifdef APPROX_MODE_EN
   input  logic        approx,
`endif
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] p,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

   // With a registered partial product the sequence needs one extra drain step.
   localparam logic [2:0] LAST_STEP = (PP_REG != 0) ? 3'd4 : 3'd3;

   state_t      state;
   state_t      state_next;
   logic [7:0]  a_q;
   logic [7:0]  b_q;
   logic [2:0]  step;
   logic [2:0]  first_step;
   logic [15:0] acc;
   logic [15:0] pp_q;
   logic [15:0] pp_shifted;
   logic [15:0] acc_sum;
   logic [3:0]  nib_a;
   logic [3:0]  nib_b;
   logic [7:0]  nib_prod;
   logic [3:0]  shamt;
   logic        accept;
   logic        last_step;

`ifdef APPROX_MODE_EN
   assign first_step = approx ? 3'd1 : 3'd0;
`else
   assign first_step = 3'd0;
`endif

   // Operand nibble selection and shift amount for the current step.
   always_comb begin
      nib_a = a_q[3:0];
      nib_b = b_q[3:0];
      shamt = 4'd0;
      case (step)
         3'd1: begin
            nib_a = a_q[7:4];
            shamt = 4'd4;
         end
         3'd2: begin
            nib_b = b_q[7:4];
            shamt = 4'd4;
         end
         3'd3: begin
            nib_a = a_q[7:4];
            nib_b = b_q[7:4];
            shamt = 4'd8;
         end
         default: ;
      endcase
   end

   assign nib_prod   = {4'b0000, nib_a} * {4'b0000, nib_b};
   assign pp_shifted = {8'b0000_0000, nib_prod} << shamt;
   assign acc_sum    = acc + ((PP_REG != 0) ? pp_q : pp_shifted);
   assign last_step  = (step == LAST_STEP);

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b1;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            busy     = 1'b0;
            in_ready = ~rst;
            accept   = in_valid & ~rst;
            if (accept)
               state_next = MUL;
         end
         MUL: begin
            if (last_step)
               state_next = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Datapath: p is loaded only on the final step so it holds through DONE and afterwards.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q  <= 8'd0;
         b_q  <= 8'd0;
         step <= 3'd0;
         acc  <= 16'd0;
         pp_q <= 16'd0;
         p    <= 16'd0;
      end else if (accept) begin
         a_q  <= a;
         b_q  <= b;
         acc  <= 16'd0;
         pp_q <= 16'd0;
         step <= first_step;
      end else if (state == MUL) begin
         if (last_step) begin
            p <= acc_sum;
         end else begin
            acc  <= acc_sum;
            pp_q <= pp_shifted;
            step <= step + 3'd1;
         end
      end
   end

endmodule

// File: tb/tb_mult8x8_seq_ctrl.sv
// Self-checking bench for mult8x8_seq_ctrl: both PP_REG settings, directed cases plus random operands.
// Expected products and latencies come from plain arithmetic on the operands.
module tb_mult8x8_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        iv   [2];
   logic        irdy [2];
   logic        ov   [2];
   logic        ordy [2];
   logic        bsy  [2];
   logic        apx  [2];
   logic [7:0]  av   [2];
   logic [7:0]  bv   [2];
   logic [15:0] pv   [2];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mult8x8_seq_ctrl #(.PP_REG(0)) dut0 (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]), .a(av[0]), .b(bv[0]),
`ifdef APPROX_MODE_EN
      .approx(apx[0]),
`endif
      .out_valid(ov[0]), .out_ready(ordy[0]), .p(pv[0]), .busy(bsy[0])
   );

   mult8x8_seq_ctrl #(.PP_REG(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]), .a(av[1]), .b(bv[1]),
`ifdef APPROX_MODE_EN
      .approx(apx[1]),
`endif
      .out_valid(ov[1]), .out_ready(ordy[1]), .p(pv[1]), .busy(bsy[1])
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] model_p(input logic [7:0] x, input logic [7:0] y, input logic ap);
      int prod;
      prod = int'(x) * int'(y);
      if (ap)
         prod = prod - (int'(x) % 16) * (int'(y) % 16);
      return prod[15:0];
   endfunction

   // One full transaction on DUT k; optionally leaves in_valid high with the next operands.
   task automatic do_op(input int k, input logic [7:0] x, input logic [7:0] y, input logic ap,
                        input int stall, input bit chain, input logic [7:0] nx, input logic [7:0] ny);
      int          lat;
      int          exp_lat;
      logic        ap_eff;
      logic [15:0] exp_p;
`ifdef APPROX_MODE_EN
      ap_eff = ap;
`else
      ap_eff = 1'b0;
`endif
      exp_p   = model_p(x, y, ap_eff);
      exp_lat = 4 + k - int'(ap_eff);
      iv[k]   = 1'b1;
      av[k]   = x;
      bv[k]   = y;
      apx[k]  = ap;
      ordy[k] = (stall == 0);
      check("in_ready_idle", irdy[k], 1);
      tick;
      if (chain) begin
         av[k] = nx;
         bv[k] = ny;
      end else begin
         iv[k]  = 1'b0;
         av[k]  = 8'($urandom);
         bv[k]  = 8'($urandom);
         apx[k] = 1'($urandom);
      end
      lat = 0;
      while (!ov[k] && lat < 20) begin
         check("busy_mul", bsy[k], 1);
         check("in_ready_mul", irdy[k], 0);
         tick;
         lat++;
      end
      check("latency", lat, exp_lat);
      check("product", pv[k], exp_p);
      for (int i = 0; i < stall; i++) begin
         tick;
         check("hold_valid", ov[k], 1);
         check("hold_p", pv[k], exp_p);
         check("in_ready_done", irdy[k], 0);
      end
      ordy[k] = 1'b1;
      tick;
      check("valid_cleared", ov[k], 0);
      check("busy_idle", bsy[k], 0);
      check("p_retained", pv[k], exp_p);
      check("in_ready_after", irdy[k], 1);
   endtask

   initial begin
      rst = 1'b1;
      for (int k = 0; k < 2; k++) begin
         iv[k] = 1'b0; av[k] = 8'd0; bv[k] = 8'd0; ordy[k] = 1'b1; apx[k] = 1'b0;
      end
      tick;
      tick;
      for (int k = 0; k < 2; k++) begin
         check("rst_p", pv[k], 0);
         check("rst_valid", ov[k], 0);
         check("rst_busy", bsy[k], 0);
         check("rst_in_ready", irdy[k], 0);
      end
      rst = 1'b0;
      #1;
      check("in_ready_released", irdy[0], 1);

      do_op(0, 8'hFF, 8'hFF, 1'b0, 0, 1'b0, 8'h00, 8'h00);
      do_op(0, 8'h00, 8'h5A, 1'b0, 0, 1'b0, 8'h00, 8'h00);
      do_op(0, 8'h1F, 8'h13, 1'b0, 3, 1'b0, 8'h00, 8'h00);
      do_op(0, 8'h12, 8'h34, 1'b0, 0, 1'b1, 8'hAB, 8'hCD);
      do_op(0, 8'hAB, 8'hCD, 1'b0, 0, 1'b0, 8'h00, 8'h00);

      // Reset in the middle of a multiply abandons it.
      iv[0] = 1'b1; av[0] = 8'hFF; bv[0] = 8'h02;
      tick;
      iv[0] = 1'b0;
      tick;
      tick;
      rst = 1'b1;
      #1;
      check("in_ready_in_rst", irdy[0], 0);
      tick;
      check("abort_valid", ov[0], 0);
      check("abort_busy", bsy[0], 0);
      check("abort_p", pv[0], 0);
      rst = 1'b0;
      #1;
      check("abort_in_ready", irdy[0], 1);
      tick;
      check("abort_no_pulse", ov[0], 0);
      do_op(0, 8'h03, 8'h05, 1'b0, 0, 1'b0, 8'h00, 8'h00);

`ifdef APPROX_MODE_EN
      do_op(0, 8'h1F, 8'h13, 1'b1, 0, 1'b0, 8'h00, 8'h00);
      do_op(0, 8'h1F, 8'h13, 1'b0, 0, 1'b0, 8'h00, 8'h00);
      do_op(1, 8'h1F, 8'h13, 1'b1, 1, 1'b0, 8'h00, 8'h00);
`endif

      do_op(1, 8'hFF, 8'hFF, 1'b0, 0, 1'b0, 8'h00, 8'h00);
      do_op(1, 8'h1F, 8'h13, 1'b0, 2, 1'b0, 8'h00, 8'h00);

      for (int n = 0; n < 24; n++)
         do_op(n % 2, 8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
               1'b0, 8'h00, 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
